minibit_exec_seq: RTL and testbench

Execute sequencer for the MiniBit datapath. It accepts instruction bytes from the fetch side and holds the current instruction for `alu_decoder`'s `bus` input. It owns the register file that drives the ALU `a`/`b` operands, and it captures the ALU result and the `pre_carry`/`pre_lt`/`pre_z` flags into architectural state. It sits around `alu_decoder` + `alu`: upstream of both, and it also consumes their outputs.

---
 rtl/minibit_pkg.sv | 17 +
 rtl/minibit_regfile.sv | 45 ++++
 rtl/minibit_exec_seq.sv | 103 ++++++++++
 tb/tb_minibit_exec_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/minibit_pkg.sv
// Shared definitions for the MiniBit execute sequencer: FSM states and instruction field positions.
package minibit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_e;

    localparam int NW_BIT = 4;
    localparam int DST_HI = 3;
    localparam int DST_LO = 2;
    localparam int SRC_HI = 1;
    localparam int SRC_LO = 0;

endpackage

// File: rtl/minibit_regfile.sv
// Register file: NREGS x WIDTH, two registered operand read ports, one comb debug port, one write port.
// Latency: operands appear one edge after rd_en; writes visible on dbg_data from the write edge.
// Backpressure: none; the caller sequences reads and writes.
module minibit_regfile #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_en,
    input  logic [AW-1:0]    ra_addr,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    logic [WIDTH-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
            a <= '0;
            b <= '0;
        end else begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            if (rd_en) begin
                a <= mem[ra_addr];
                b <= mem[rb_addr];
            end
        end
    end

    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/minibit_exec_seq.sv
// Execute sequencer: latches an instruction, feeds ALU operands, captures result and flags, writes back.
// Latency: accept -> operands +1 -> flags/res +2 -> done during next cycle, write at +3; 4 cycles per instruction.
// Backpressure: instr_ready only in IDLE; preloads outside IDLE are dropped.
module minibit_exec_seq
    import minibit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [7:0]       ir,
    output logic             fl_carry,
    output logic             fl_lt,
    output logic             fl_z,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] o,
    input  logic             pre_carry,
    input  logic             pre_lt,
    input  logic             pre_z,
    input  logic             ld_en,
    input  logic [1:0]       ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [1:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic             busy,
    output logic             done
);

    state_e           state;
    logic [WIDTH-1:0] res;
    logic             wb_we;
    logic             ld_we;
    logic             rf_we;
    logic [1:0]       rf_waddr;
    logic [WIDTH-1:0] rf_wdata;

    assign instr_ready = (state == IDLE) && !rst;
    assign busy        = (state != IDLE);
    assign done        = (state == WB) && !rst;

    // Preload and writeback are mutually exclusive by state, so a simple priority mux suffices.
    assign wb_we    = (state == WB) && !ir[NW_BIT];
    assign ld_we    = (state == IDLE) && ld_en;
    assign rf_we    = wb_we || ld_we;
    assign rf_waddr = wb_we ? ir[DST_HI:DST_LO] : ld_addr;
    assign rf_wdata = wb_we ? res : ld_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ir       <= '0;
            res      <= '0;
            fl_carry <= 1'b0;
            fl_lt    <= 1'b0;
            fl_z     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        ir    <= instr;
                        state <= READ;
                    end
                end
                READ: state <= EXEC;
                EXEC: begin
                    // fl_carry only changes here, so the decoder sees the previous instruction's carry.
                    res      <= o;
                    fl_carry <= pre_carry;
                    fl_lt    <= pre_lt;
                    fl_z     <= pre_z;
                    state    <= WB;
                end
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    minibit_regfile #(
        .WIDTH(WIDTH),
        .NREGS(NREGS),
        .AW   (2)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .rd_en   (state == READ),
        .ra_addr (ir[DST_HI:DST_LO]),
        .rb_addr (ir[SRC_HI:SRC_LO]),
        .a       (a),
        .b       (b),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

endmodule

// File: tb/tb_minibit_exec_seq.sv
// Directed bench for minibit_exec_seq with an adder stub standing in for alu_decoder + alu.
module tb_minibit_exec_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] ir;
    logic       fl_carry, fl_lt, fl_z;
    logic [7:0] a, b, o;
    logic       pre_carry, pre_lt, pre_z;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;
    logic       busy, done;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    assign {pre_carry, o} = {1'b0, a} + {1'b0, b};
    assign pre_lt = (a < b);
    assign pre_z  = (o == 8'h00);

    minibit_exec_seq dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .ir(ir), .fl_carry(fl_carry), .fl_lt(fl_lt),
        .fl_z(fl_z), .a(a), .b(b), .o(o), .pre_carry(pre_carry), .pre_lt(pre_lt),
        .pre_z(pre_z), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy), .done(done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [1:0] addr, input logic [7:0] data);
        ld_en = 1'b1; ld_addr = addr; ld_data = data;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic issue(input logic [7:0] op);
        instr = op; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; instr = 8'h61; instr_valid = 1'b1;
        ld_en = 1'b0; ld_addr = 2'd0; ld_data = 8'h00; dbg_addr = 2'd0;
        tick();
        vecs++; if (instr_ready !== 1'b0) begin errs++; $display("FAIL rst_ready_low got %b want 0", instr_ready); end
        tick();
        rst = 1'b0; instr_valid = 1'b0;
        #1;
        vecs++; if (instr_ready !== 1'b1) begin errs++; $display("FAIL rst_ready got %b want 1", instr_ready); end
        vecs++; if ({fl_carry, fl_lt, fl_z} !== 3'b000) begin errs++; $display("FAIL rst_flags got %b want 000", {fl_carry, fl_lt, fl_z}); end
        vecs++; if ({done, busy} !== 2'b00) begin errs++; $display("FAIL rst_done_busy got %b want 00", {done, busy}); end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i); #1;
            vecs++; if (dbg_data !== 8'h00) begin errs++; $display("FAIL rst_reg%0d got %h want 00", i, dbg_data); end
        end
    endtask

    task automatic test_basic_add();
        preload(2'd0, 8'h09);
        preload(2'd1, 8'h02);
        issue(8'h61);
        vecs++; if ({busy, done} !== 2'b10) begin errs++; $display("FAIL add_read got busy/done %b want 10", {busy, done}); end
        tick();
        vecs++; if ({a, b} !== 16'h0902) begin errs++; $display("FAIL add_operands got %h want 0902", {a, b}); end
        vecs++; if (done !== 1'b0) begin errs++; $display("FAIL add_exec_done got %b want 0", done); end
        tick();
        vecs++; if (done !== 1'b1) begin errs++; $display("FAIL add_done got %b want 1", done); end
        vecs++; if ({fl_carry, fl_lt, fl_z} !== 3'b000) begin errs++; $display("FAIL add_flags got %b want 000", {fl_carry, fl_lt, fl_z}); end
        tick();
        dbg_addr = 2'd0; #1;
        vecs++; if (dbg_data !== 8'h0B) begin errs++; $display("FAIL add_r0 got %h want 0b", dbg_data); end
        vecs++; if ({done, instr_ready} !== 2'b01) begin errs++; $display("FAIL add_idle got done/ready %b want 01", {done, instr_ready}); end
    endtask

    task automatic test_carry_zero();
        preload(2'd2, 8'hFF);
        preload(2'd3, 8'h01);
        issue(8'h6B);
        tick();
        vecs++; if (fl_carry !== 1'b0) begin errs++; $display("FAIL cz_exec_carry got %b want 0", fl_carry); end
        vecs++; if (ir !== 8'h6B) begin errs++; $display("FAIL cz_ir got %h want 6b", ir); end
        tick();
        vecs++; if ({fl_carry, fl_lt, fl_z} !== 3'b101) begin errs++; $display("FAIL cz_flags got %b want 101", {fl_carry, fl_lt, fl_z}); end
        tick();
        dbg_addr = 2'd2; #1;
        vecs++; if (dbg_data !== 8'h00) begin errs++; $display("FAIL cz_r2 got %h want 00", dbg_data); end
    endtask

    task automatic test_no_write();
        preload(2'd0, 8'h04);
        preload(2'd1, 8'h0F);
        issue(8'h71);
        tick(); tick();
        vecs++; if (done !== 1'b1) begin errs++; $display("FAIL nw_done got %b want 1", done); end
        vecs++; if ({fl_carry, fl_lt, fl_z} !== 3'b010) begin errs++; $display("FAIL nw_flags got %b want 010", {fl_carry, fl_lt, fl_z}); end
        tick();
        dbg_addr = 2'd0; #1;
        vecs++; if (dbg_data !== 8'h04) begin errs++; $display("FAIL nw_r0 got %h want 04", dbg_data); end
        tick();
        vecs++; if ({fl_carry, fl_lt, fl_z} !== 3'b010) begin errs++; $display("FAIL nw_flag_hold got %b want 010", {fl_carry, fl_lt, fl_z}); end
    endtask

    task automatic test_preload_busy();
        issue(8'h71);
        ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'hAA;
        tick(); tick(); tick();
        ld_en = 1'b0;
        dbg_addr = 2'd0; #1;
        vecs++; if (dbg_data !== 8'h04) begin errs++; $display("FAIL busy_preload_r0 got %h want 04", dbg_data); end
        preload(2'd0, 8'h55);
        vecs++; if (dbg_data !== 8'h55) begin errs++; $display("FAIL idle_preload_r0 got %h want 55", dbg_data); end
        // Preload r1 and accept in the same cycle: READ must see the new r1.
        ld_en = 1'b1; ld_addr = 2'd1; ld_data = 8'h10;
        issue(8'h61);
        ld_en = 1'b0;
        tick();
        vecs++; if ({a, b} !== 16'h5510) begin errs++; $display("FAIL same_cycle_operands got %h want 5510", {a, b}); end
        tick(); tick();
        #1;
        vecs++; if (dbg_data !== 8'h65) begin errs++; $display("FAIL same_cycle_r0 got %h want 65", dbg_data); end
    endtask

    task automatic test_back_to_back();
        instr = 8'h61; instr_valid = 1'b1;
        tick();
        tick(); tick();
        vecs++; if (done !== 1'b1) begin errs++; $display("FAIL b2b_done1 got %b want 1", done); end
        tick();
        vecs++; if ({instr_ready, busy} !== 2'b10) begin errs++; $display("FAIL b2b_idle got ready/busy %b want 10", {instr_ready, busy}); end
        vecs++; if (dbg_data !== 8'h75) begin errs++; $display("FAIL b2b_r0_first got %h want 75", dbg_data); end
        tick();
        instr_valid = 1'b0;
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL b2b_second_accept got busy %b want 1", busy); end
        tick(); tick();
        vecs++; if (done !== 1'b1) begin errs++; $display("FAIL b2b_done2 got %b want 1", done); end
        tick();
        vecs++; if (dbg_data !== 8'h85) begin errs++; $display("FAIL b2b_r0_second got %h want 85", dbg_data); end
    endtask

    task automatic test_reset_mid_op();
        issue(8'h61);
        tick();
        rst = 1'b1;
        #1;
        vecs++; if (instr_ready !== 1'b0) begin errs++; $display("FAIL midrst_ready got %b want 0", instr_ready); end
        tick();
        rst = 1'b0;
        #1;
        vecs++; if ({done, busy} !== 2'b00) begin errs++; $display("FAIL midrst_state got done/busy %b want 00", {done, busy}); end
        dbg_addr = 2'd0; #1;
        vecs++; if (dbg_data !== 8'h00) begin errs++; $display("FAIL midrst_r0 got %h want 00", dbg_data); end
        vecs++; if ({fl_carry, fl_lt, fl_z} !== 3'b000) begin errs++; $display("FAIL midrst_flags got %b want 000", {fl_carry, fl_lt, fl_z}); end
        tick();
        vecs++; if (done !== 1'b0) begin errs++; $display("FAIL midrst_no_done got %b want 0", done); end
        preload(2'd0, 8'h03);
        preload(2'd1, 8'h04);
        issue(8'h61);
        tick(); tick();
        vecs++; if (done !== 1'b1) begin errs++; $display("FAIL midrst_next_done got %b want 1", done); end
        tick();
        vecs++; if (dbg_data !== 8'h07) begin errs++; $display("FAIL midrst_next_r0 got %h want 07", dbg_data); end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_carry_zero();
        test_no_write();
        test_preload_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
